// File: rtl/cpu_pkg.sv
// Shared definitions for the Z-register sequencer, the control unit and the bench:
// ALU op encodings, sequencer state encoding and small op-classification helpers.
package cpu_pkg;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXEC    = 3'd1,
    ST_LATCH   = 3'd2,
    ST_XFER_LO = 3'd3,
    ST_XFER_HI = 3'd4,
    ST_DONE    = 3'd5
  } z_state_e;

  // Mul and div produce a 64-bit result that needs both LO and HI transfers.
  function automatic logic is_wide_op(input logic [1:0] op_v);
    is_wide_op = (op_v == OP_MUL) || (op_v == OP_DIV);
  endfunction

endpackage

// File: rtl/z_lat_counter.sv
// Latency down-counter for the EXEC phase: loads N-1 on launch, decrements
// while enabled and saturates at zero so it can never wrap.
module z_lat_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Counter register: reset wins, then load, then saturating decrement.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= {W{1'b0}};
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != {W{1'b0}})) begin
      count <= count - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign zero = (count == {W{1'b0}});

endmodule

// File: rtl/z_seq_ctrl.sv
// Z-register / bus sequencer: launches an ALU op, waits its latency, latches
// the result into Z and moves it onto the bus (RZ or LO, then HI for mul/div)
// under a request/grant handshake. Outputs are decoded from registered state,
// counter, latched op and the current grant so a grant is used in-cycle.
module z_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int MUL_LAT = 1,
  parameter int DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       bus_gnt,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       alu_go,
  output logic       bus_req,
  output logic       ZInput,
  output logic       ZLowOut,
  output logic       ZHighOut,
  output logic       LOin,
  output logic       HIin,
  output logic       RZin
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  // Counter preload for a given op; single-word and illegal ops use zero.
  function automatic logic [CW-1:0] lat_load(input logic [1:0] op_v);
    case (op_v)
      OP_MUL:  lat_load = MUL_LOAD;
      OP_DIV:  lat_load = DIV_LOAD;
      default: lat_load = {CW{1'b0}};
    endcase
  endfunction

  z_state_e      state_r;
  logic [1:0]    op_r;
  logic [CW-1:0] cnt_s;
  logic          cnt_zero_s;
  logic          cnt_load_s;
  logic          cnt_dec_s;

  // Launch loads the counter at the accepting edge so the first EXEC cycle
  // already reads N-1; the counter only moves while in EXEC.
  assign cnt_load_s = (state_r == ST_IDLE) && start;
  assign cnt_dec_s  = (state_r == ST_EXEC);

  z_lat_counter #(
    .W (CW)
  ) u_lat_counter (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load_s),
    .load_val (lat_load(op)),
    .dec      (cnt_dec_s),
    .count    (cnt_s),
    .zero     (cnt_zero_s)
  );

  // Sequencer FSM: state and latched op, synchronous clear to IDLE / OP_ALU.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= ST_IDLE;
      op_r    <= OP_ALU;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_r    <= op;
            state_r <= (op == OP_ILL) ? ST_DONE : ST_EXEC;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          state_r <= cnt_zero_s ? ST_LATCH : ST_EXEC;
        end
        ST_LATCH: begin
          state_r <= ST_XFER_LO;
        end
        ST_XFER_LO: begin
          if (bus_gnt) begin
            state_r <= is_wide_op(op_r) ? ST_XFER_HI : ST_DONE;
          end else begin
            state_r <= ST_XFER_LO;
          end
        end
        ST_XFER_HI: begin
          state_r <= bus_gnt ? ST_DONE : ST_XFER_HI;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode: one Z source and one destination enable at most per cycle;
  // transfer strobes fire only in a granted transfer cycle.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    alu_go   = 1'b0;
    bus_req  = 1'b0;
    ZInput   = 1'b0;
    ZLowOut  = 1'b0;
    ZHighOut = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    RZin     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_EXEC: begin
        busy   = 1'b1;
        // Counter still holds its preload only in the first EXEC cycle.
        alu_go = (cnt_s == lat_load(op_r));
      end
      ST_LATCH: begin
        busy   = 1'b1;
        ZInput = 1'b1;
      end
      ST_XFER_LO: begin
        busy    = 1'b1;
        bus_req = 1'b1;
        if (bus_gnt) begin
          ZLowOut = 1'b1;
          LOin    = is_wide_op(op_r);
          RZin    = ~is_wide_op(op_r);
        end else begin
          ZLowOut = 1'b0;
        end
      end
      ST_XFER_HI: begin
        busy    = 1'b1;
        bus_req = 1'b1;
        if (bus_gnt) begin
          ZHighOut = 1'b1;
          HIin     = 1'b1;
        end else begin
          ZHighOut = 1'b0;
        end
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
        err  = (op_r == OP_ILL);
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
